// File: rtl/switch_arbiter_if.sv
// switch_arbiter_if: port-side request/data lines and arbiter grant/write/data outputs of the central switch.
interface switch_arbiter_if #(
  parameter int AW_DEV = 2,
  parameter int DW = 4
);
  localparam int N = 1 << AW_DEV;
  logic [N-1:0] rqt;
  logic [N-1:0] validtx;
  logic [N*AW_DEV-1:0] adr_i;
  logic [N*DW-1:0] dat_i;
  logic [N-1:0] full_array;
  logic [N-1:0] gnt;
  logic [N-1:0] wen;
  logic [DW-1:0] fifo_o;
  logic busy;
  modport master (
    output rqt, validtx, adr_i, dat_i, full_array,
    input gnt, wen, fifo_o, busy
  );
  modport slave (
    input rqt, validtx, adr_i, dat_i, full_array,
    output gnt, wen, fifo_o, busy
  );
endinterface

// File: rtl/switch_arbiter.sv
// switch_arbiter: round-robin grant of one port at a time, one-cycle word transfer, then wait for the winner's handshake release.
module switch_arbiter #(
  parameter int AW_DEV = 2,
  parameter int DW = 4
) (
  input logic clk_i,
  input logic rst_ni,
  switch_arbiter_if.slave bus
);
  localparam int N = 1 << AW_DEV;
  typedef enum logic [1:0] {IDLE, XFER, RELEASE} state_t;
  state_t state, state_n;
  logic [AW_DEV-1:0] ptr, ptr_n, w, w_n, dst, dst_n, win, idx;
  logic [DW-1:0] dat, dat_n, fifo, fifo_n;
  logic [N-1:0] gnt, gnt_n, wen, wen_n, elig;
  logic found;
  always_comb begin
    elig = '0;
    for (int k = 0; k < N; k++)
      elig[k] = bus.rqt[k] & bus.validtx[k] & ~bus.full_array[bus.adr_i[k*AW_DEV +: AW_DEV]];
  end
  // first eligible port at or after ptr, wrapping modulo N
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      idx = ptr + AW_DEV'(i);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    w_n = w;
    dst_n = dst;
    dat_n = dat;
    fifo_n = fifo;
    gnt_n = '0;
    wen_n = '0;
    case (state)
      IDLE: if (found) begin
        state_n = XFER;
        w_n = win;
        dst_n = bus.adr_i[win*AW_DEV +: AW_DEV];
        dat_n = bus.dat_i[win*DW +: DW];
        gnt_n = N'(1) << win;
        wen_n = N'(1) << dst_n;
        fifo_n = dat_n;
      end
      XFER: state_n = RELEASE;
      RELEASE: if (!bus.validtx[w]) begin
        state_n = IDLE;
        ptr_n = w + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      ptr <= '0;
      w <= '0;
      dst <= '0;
      dat <= '0;
      fifo <= '0;
      gnt <= '0;
      wen <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      w <= w_n;
      dst <= dst_n;
      dat <= dat_n;
      fifo <= fifo_n;
      gnt <= gnt_n;
      wen <= wen_n;
    end
  end
  assign bus.gnt = gnt;
  assign bus.wen = wen;
  assign bus.fifo_o = fifo;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_switch_arbiter.sv
// tb_switch_arbiter: directed steps with hand-computed grant/write/data expectations for a 4-port switch_arbiter.
module tb_switch_arbiter;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int errors = 0;
  int checks = 0;
  switch_arbiter_if #(.AW_DEV(2), .DW(4)) bus ();
  switch_arbiter #(.AW_DEV(2), .DW(4)) dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));
  always #5 clk_i = ~clk_i;
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask
  task automatic set_port(input int k, input logic on, input logic [1:0] a, input logic [3:0] d);
    bus.rqt[k] = on;
    bus.validtx[k] = on;
    bus.adr_i[k*2 +: 2] = a;
    bus.dat_i[k*4 +: 4] = d;
  endtask
  // arbitration edge -> XFER checks, then one edge -> RELEASE checks
  task automatic xfer(input string tag, input logic [3:0] g, input logic [3:0] wr, input logic [3:0] d);
    tick();
    chk({tag, "_gnt"}, bus.gnt, g);
    chk({tag, "_wen"}, bus.wen, wr);
    chk({tag, "_fifo"}, bus.fifo_o, d);
    chk({tag, "_busy"}, {3'b0, bus.busy}, 4'h1);
    tick();
    chk({tag, "_rel_gnt"}, bus.gnt, 4'h0);
    chk({tag, "_rel_wen"}, bus.wen, 4'h0);
    chk({tag, "_rel_fifo"}, bus.fifo_o, d);
    chk({tag, "_rel_busy"}, {3'b0, bus.busy}, 4'h1);
  endtask
  task automatic release_port(input string tag, input int k);
    bus.rqt[k] = 1'b0;
    bus.validtx[k] = 1'b0;
    tick();
    chk({tag, "_idle_busy"}, {3'b0, bus.busy}, 4'h0);
    chk({tag, "_idle_gnt"}, bus.gnt, 4'h0);
  endtask
  initial begin
    int k;
    bus.rqt = '0;
    bus.validtx = '0;
    bus.adr_i = '0;
    bus.dat_i = '0;
    bus.full_array = '0;
    tick();
    tick();
    chk("rst_gnt", bus.gnt, 4'h0);
    chk("rst_wen", bus.wen, 4'h0);
    chk("rst_fifo", bus.fifo_o, 4'h0);
    chk("rst_busy", {3'b0, bus.busy}, 4'h0);
    rst_ni = 1'b1;
    tick();
    set_port(1, 1'b1, 2'd3, 4'hA);
    xfer("single", 4'b0010, 4'b1000, 4'hA);
    release_port("single", 1);
    set_port(1, 1'b1, 2'd3, 4'hB);
    set_port(2, 1'b1, 2'd0, 4'hC);
    xfer("ptr2", 4'b0100, 4'b0001, 4'hC);
    release_port("ptr2", 2);
    set_port(3, 1'b1, 2'd3, 4'hD);
    xfer("loop", 4'b1000, 4'b1000, 4'hD);
    release_port("loop", 3);
    set_port(1, 1'b0, 2'd0, 4'h0);
    for (int i = 0; i < 4; i++) set_port(i, 1'b1, 2'((i + 1) % 4), 4'(i + 5));
    for (int i = 0; i < 5; i++) begin
      k = i % 4;
      xfer("rr", 4'(1 << k), 4'(1 << ((k + 1) % 4)), 4'(k + 5));
      release_port("rr", k);
      set_port(k, 1'b1, 2'((k + 1) % 4), 4'(k + 5));
    end
    for (int i = 0; i < 4; i++) set_port(i, 1'b0, 2'd0, 4'h0);
    set_port(2, 1'b1, 2'd1, 4'h6);
    tick();
    chk("arst_pre_gnt", bus.gnt, 4'b0100);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_gnt", bus.gnt, 4'h0);
    chk("arst_wen", bus.wen, 4'h0);
    chk("arst_busy", {3'b0, bus.busy}, 4'h0);
    set_port(2, 1'b0, 2'd0, 4'h0);
    tick();
    rst_ni = 1'b1;
    set_port(0, 1'b1, 2'd1, 4'h7);
    set_port(3, 1'b1, 2'd2, 4'h8);
    xfer("arst_ptr0", 4'b0001, 4'b0010, 4'h7);
    release_port("arst_ptr0", 0);
    xfer("arst_next", 4'b1000, 4'b0100, 4'h8);
    release_port("arst_next", 3);
    bus.full_array = 4'b0100;
    set_port(0, 1'b1, 2'd2, 4'h1);
    set_port(1, 1'b1, 2'd3, 4'h2);
    xfer("full", 4'b0010, 4'b1000, 4'h2);
    release_port("full", 1);
    tick();
    chk("full_skip_gnt", bus.gnt, 4'h0);
    chk("full_skip_busy", {3'b0, bus.busy}, 4'h0);
    bus.full_array = 4'b0000;
    xfer("full_clr", 4'b0001, 4'b0100, 4'h1);
    release_port("full_clr", 0);
    set_port(1, 1'b1, 2'd0, 4'h3);
    xfer("held", 4'b0010, 4'b0001, 4'h3);
    set_port(2, 1'b1, 2'd1, 4'h4);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("held_gnt", bus.gnt, 4'h0);
      chk("held_busy", {3'b0, bus.busy}, 4'h1);
    end
    release_port("held", 1);
    xfer("held_p2", 4'b0100, 4'b0010, 4'h4);
    release_port("held_p2", 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/switch_arbiter.md
# switch_arbiter

Round-robin arbiter and transfer sequencer for the central switch. It collects the `rqt` lines of all N ports and grants one port at a time. It moves the winner's word onto the shared switch data bus and pulses the destination port's FIFO write enable. It then holds off further grants until the winner's 4-phase TX handshake has released.

## Interface
Parameters:
- AW_DEV, 2, port address width; N = 1<<AW_DEV ports
- DW, 4, data width

Ports:
- clk_i  in  1  single clock; all logic rises on posedge
- rst_ni  in  1  asynchronous, active-low reset
- rqt  in  N  per-port request (port has `validtx` and its destination is not full)
- validtx  in  N  per-port raw `validtx`, used to detect handshake release
- adr_i  in  N*AW_DEV  per-port destination address; port k occupies [k*AW_DEV +: AW_DEV]
- dat_i  in  N*DW  per-port TX data; port k occupies [k*DW +: DW]
- full_array  in  N  per-port FIFO full flags
- gnt  out  N  one-hot grant to the source port
- wen  out  N  one-hot write enable to the destination port FIFO
- fifo_o  out  DW  shared switch data bus, wired to every port's `fifo_i`
- busy  out  1  high whenever state != IDLE

## Operation
- State machine: IDLE -> XFER -> RELEASE -> IDLE. All outputs are registered.
- **IDLE**
  - Eligible port k: rqt[k] & validtx[k] & ~full_array[adr_k].
  - Search starts at pointer `ptr` and wraps modulo N; the first eligible port wins.
  - On a winner: latch w, dst = adr_w and dat_w; go to XFER.
  - No eligible port: stay in IDLE; outputs stay 0.
- **XFER** (exactly one cycle)
  - gnt[w]=1, wen[dst]=1, fifo_o=latched data.
  - Always go to RELEASE.
  - A port may not drop `validtx` before it sees `acktx`, so the write is committed unconditionally.
- **RELEASE**
  - gnt=0, wen=0, fifo_o holds the last value.
  - Wait until validtx[w]==0, then go to IDLE and set ptr = (w+1) mod N (wraps from N-1 to 0).
  - While in RELEASE, no other port is granted, even if it requests.
- A port may request its own address (loopback). Source and destination are independent one-hots.
- full_array is re-sampled in IDLE only. RELEASE always lasts at least one cycle, so the FIFO full flag has updated after the previous write.
- Ineligible requesters (destination full) are skipped without blocking the others. `ptr` changes only on transfer completion.

## Timing
- Reset values: state=IDLE, ptr=0, gnt=0, wen=0, fifo_o=0, busy=0, latched w/dst/data=0.
- Reset asserted mid-transfer: gnt and wen clear immediately (asynchronously). The pending transfer is dropped and not replayed.
- Latency from eligible rqt sampled in IDLE (cycle t):
  - gnt and wen high in cycle t+1, for exactly one cycle.
  - Port acktx rises at t+2.
- Earliest next grant:
  - The cycle after validtx[w] is sampled low in RELEASE.
  - Minimum back-to-back spacing is 3 cycles: IDLE, XFER, RELEASE.
- Requests are sampled only in IDLE. A rqt that rises and falls entirely within XFER/RELEASE is never granted.
- Simultaneous requests are resolved only by `ptr` order. Every requester is served within N transfers.
- wen is never asserted for a FIFO whose full flag was high in the arbitration cycle.

## Test plan
- **Single transfer:** N=4, port 1 raises rqt/validtx with adr=3, dat=4'hA.
  - Required: gnt=4'b0010 and wen=4'b1000 for one cycle, fifo_o=4'hA, busy high.
  - Port drops validtx two cycles later -> IDLE, ptr=2.
- **Round robin:** all four ports request continuously to distinct non-full destinations starting with ptr=0.
  - Required: grants in order 0,1,2,3,0; never two grants inside one transfer.
- **Full destination:** full_array=4'b0100; port 0 targets 2, port 1 targets 3, ptr=0.
  - Required: port 1 is granted first and port 0 is skipped.
  - After full_array[2] clears, port 0 is granted.
- **Held release:** winner keeps validtx high for 10 cycles after acktx while port 2 requests.
  - Required: gnt stays 0 throughout; port 2 is granted the cycle after the release is seen.
- **Loopback and wrap:** port 3 targets 3 with ptr=3.
  - Required: gnt=wen=4'b1000; ptr wraps to 0 afterwards.
- **Async reset:** drop rst_ni during XFER.
  - Required: gnt, wen and busy go 0 without waiting for a clock edge.
  - After release, the first request is arbitrated from ptr=0.
